// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state codes, reference format and carrier constants for the PWM update controller.
//   state_e       : IDLE=0, PRECHARGE=1, RUN=2, STOP=3, FAULT=4
//   REF_W/MAG_W   : 24-bit sign-magnitude reference, 23-bit 11.12 magnitude, sign at SIGN_BIT
//   CARRIER_PEAK  : carrier peak magnitude shared with the modulator, also the default clamp limit
package pwm_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOP      = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;
  localparam int SIGN_BIT = 23;
  localparam int MAG_W = 23;
  localparam int REF_W = 24;
  localparam logic [MAG_W-1:0] CARRIER_PEAK = 23'h22BF10;
  localparam logic [MAG_W-1:0] DEFAULT_MAX_MAG = CARRIER_PEAK;
endpackage

// File: rtl/pwm_ref_sat.sv
// pwm_ref_sat: clamps one sign-magnitude reference to MAX_MAG and normalises negative zero.
//   ref_i     : raw reference (bit 23 sign, 22:0 magnitude)
//   ref_o     : clamped, normalised reference
//   clamped_o : magnitude exceeded MAX_MAG
module pwm_ref_sat
  import pwm_ctrl_pkg::*;
#(
  parameter logic [MAG_W-1:0] MAX_MAG = DEFAULT_MAX_MAG
) (
  input  logic [REF_W-1:0] ref_i,
  output logic [REF_W-1:0] ref_o,
  output logic             clamped_o
);
  logic [MAG_W-1:0] mag;
  assign clamped_o = ref_i[MAG_W-1:0] > MAX_MAG;
  assign mag = clamped_o ? MAX_MAG : ref_i[MAG_W-1:0];
  // a zero magnitude always leaves with a positive sign
  assign ref_o = {ref_i[SIGN_BIT] & (mag != '0), mag};
endmodule

// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl: shadowed reference handshake, carrier-synchronous commit and arm/precharge/run/stop/fault sequencing.
//   clk, reset (async, active-low)
//   arm, fault_n, fault_clr          : control inputs
//   car_min, car_max                 : carrier extreme pulses
//   ref_valid/ref_ready, ref_u[abc]  : reference handshake into the shadow stage
//   u[abc], commit, sat              : committed references and commit/saturation pulses
//   gate_en, lowside_force, state    : half-bridge gating and current state code
// PWM_CTRL_DUAL_UPDATE_EN: when defined, car_max is also a commit boundary.
module pwm_update_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned      PRECHARGE_PERIODS = 8,
  parameter logic [MAG_W-1:0] MAX_MAG           = DEFAULT_MAX_MAG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             fault_n,
  input  logic             fault_clr,
  input  logic             car_min,
  input  logic             car_max,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [REF_W-1:0] ref_ua,
  input  logic [REF_W-1:0] ref_ub,
  input  logic [REF_W-1:0] ref_uc,
  output logic [REF_W-1:0] ua,
  output logic [REF_W-1:0] ub,
  output logic [REF_W-1:0] uc,
  output logic             gate_en,
  output logic             lowside_force,
  output logic             commit,
  output logic             sat,
  output logic [2:0]       state
);
  localparam logic [7:0] PRE_CNT = 8'(PRECHARGE_PERIODS);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic sh_full_q, sh_full_d, sh_sat_q, sh_sat_d;
  logic [REF_W-1:0] sh_a_q, sh_b_q, sh_c_q, sh_a_d, sh_b_d, sh_c_d;
  logic [REF_W-1:0] ua_q, ub_q, uc_q, ua_d, ub_d, uc_d;
  logic gate_q, gate_d, low_q, low_d, commit_q, commit_d, sat_q, sat_d;
  logic [REF_W-1:0] sat_a, sat_b, sat_c;
  logic clp_a, clp_b, clp_c;
  logic accept, bnd, do_commit;
  pwm_ref_sat #(.MAX_MAG(MAX_MAG)) u_sat_a (.ref_i(ref_ua), .ref_o(sat_a), .clamped_o(clp_a));
  pwm_ref_sat #(.MAX_MAG(MAX_MAG)) u_sat_b (.ref_i(ref_ub), .ref_o(sat_b), .clamped_o(clp_b));
  pwm_ref_sat #(.MAX_MAG(MAX_MAG)) u_sat_c (.ref_i(ref_uc), .ref_o(sat_c), .clamped_o(clp_c));
`ifdef PWM_CTRL_DUAL_UPDATE_EN
  assign bnd = car_min | car_max;
`else
  logic unused_car_max;
  assign unused_car_max = car_max;
  assign bnd = car_min;
`endif
  assign ref_ready = ~sh_full_q & (state_q != ST_FAULT);
  assign accept = ref_valid & ref_ready;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    do_commit = 1'b0;
    if (!fault_n) state_d = ST_FAULT;
    else begin
      case (state_q)
        ST_IDLE: if (arm) begin
          state_d = ST_PRECHARGE;
          cnt_d = '0;
        end
        ST_PRECHARGE: if (!arm) state_d = ST_IDLE;
        else if (car_min) begin
          cnt_d = cnt_inc;
          state_d = (cnt_inc >= PRE_CNT) ? ST_RUN : ST_PRECHARGE;
        end
        ST_RUN: if (!arm) state_d = ST_STOP;
        else do_commit = bnd & sh_full_q;
        ST_STOP: if (car_min) state_d = ST_IDLE;
        ST_FAULT: if (fault_clr && !arm) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // accept and commit never coincide: a commit needs a full shadow, which deasserts ref_ready
  assign sh_full_d = !fault_n ? 1'b0 : accept ? 1'b1 : do_commit ? 1'b0 : sh_full_q;
  assign sh_a_d = accept ? sat_a : sh_a_q;
  assign sh_b_d = accept ? sat_b : sh_b_q;
  assign sh_c_d = accept ? sat_c : sh_c_q;
  assign sh_sat_d = accept ? (clp_a | clp_b | clp_c) : sh_sat_q;
  // references are only non-zero while staying in RUN
  assign ua_d = (state_d != ST_RUN) ? '0 : do_commit ? sh_a_q : ua_q;
  assign ub_d = (state_d != ST_RUN) ? '0 : do_commit ? sh_b_q : ub_q;
  assign uc_d = (state_d != ST_RUN) ? '0 : do_commit ? sh_c_q : uc_q;
  assign gate_d = (state_d == ST_RUN) | (state_d == ST_STOP);
  assign low_d = state_d == ST_PRECHARGE;
  assign commit_d = do_commit;
  assign sat_d = do_commit & sh_sat_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sh_full_q <= 1'b0;
      sh_sat_q <= 1'b0;
      sh_a_q <= '0;
      sh_b_q <= '0;
      sh_c_q <= '0;
      ua_q <= '0;
      ub_q <= '0;
      uc_q <= '0;
      gate_q <= 1'b0;
      low_q <= 1'b0;
      commit_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_full_q <= sh_full_d;
      sh_sat_q <= sh_sat_d;
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
      sh_c_q <= sh_c_d;
      ua_q <= ua_d;
      ub_q <= ub_d;
      uc_q <= uc_d;
      gate_q <= gate_d;
      low_q <= low_d;
      commit_q <= commit_d;
      sat_q <= sat_d;
    end
  end
  assign ua = ua_q;
  assign ub = ub_q;
  assign uc = uc_q;
  assign gate_en = gate_q;
  assign lowside_force = low_q;
  assign commit = commit_q;
  assign sat = sat_q;
  assign state = state_q;
endmodule

// File: doc/pwm_update_ctrl.md
# pwm_update_ctrl

Sequencing controller for the three-phase sign-magnitude PWM modulator. It accepts phase-voltage references from the vector-control loop over a valid/ready handshake and buffers them in a shadow stage. References are committed to the modulator only at carrier boundaries. The block also runs the arm / bootstrap-precharge / run / stop / fault state machine that gates the half-bridge outputs.

## Interface
Parameters:
- PRECHARGE_PERIODS, 8: number of carrier periods (car_min pulses) with low sides forced on before RUN; legal range 1..255.
- MAX_MAG, 23'h22BF10: magnitude saturation limit, 11.12 fixed point, equal to the carrier peak of 555.94140625.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  level; 1 requests running, 0 requests stop.
- fault_n  in  1  external fault, active-low; synchronous to clk.
- fault_clr  in  1  one-cycle pulse to leave FAULT.
- car_min  in  1  one-cycle pulse at the carrier negative extreme.
- car_max  in  1  one-cycle pulse at the carrier positive extreme.
- ref_valid  in  1  reference triple valid.
- ref_ready  out  1  shadow stage free.
- ref_ua, ref_ub, ref_uc  in  24  references; bit 23 is sign (1 = negative), bits 22:0 are magnitude in 11.12.
- ua, ub, uc  out  24  committed references to the modulator, same format.
- gate_en  out  1  enables PWM gate outputs.
- lowside_force  out  1  forces all N-side switches on (bootstrap charge).
- commit  out  1  one-cycle pulse when ua/ub/uc are loaded.
- sat  out  1  one-cycle pulse with commit if any channel was clamped.
- state  out  3  current state code.

## Operation
State codes: IDLE=0, PRECHARGE=1, RUN=2, STOP=3, FAULT=4.
- **IDLE**: gate_en=0, lowside_force=0, ua/ub/uc=0.
  - Moves to PRECHARGE when arm=1 and fault_n=1; the precharge counter clears.
- **PRECHARGE**: lowside_force=1, gate_en=0, outputs stay 0.
  - Each car_min increments the counter.
  - The cycle that sees the PRECHARGE_PERIODS-th car_min moves to RUN.
  - arm=0 returns to IDLE.
- **RUN**: gate_en=1, lowside_force=0.
  - At each commit boundary with the shadow full, the shadow is loaded into ua/ub/uc. commit pulses and the shadow empties.
  - With the shadow empty, outputs hold.
  - arm=0 moves to STOP; ua/ub/uc clear to 0 on that same edge.
- **STOP**: gate_en=1 with zero references. The next car_min moves to IDLE.
- **FAULT**: entered from any state when fault_n=0. Fault has priority over every other transition.
  - Same edge: gate_en=0, lowside_force=0, ua/ub/uc=0, shadow flushed.
  - ref_ready=0 while in FAULT.
  - Leaves to IDLE only when fault_clr=1, fault_n=1 and arm=0 in the same cycle. A clear with arm=1 is ignored.
- **Handshake**:
  - ref_ready = shadow empty and state≠FAULT.
  - The transfer occurs on a clock edge with ref_valid & ref_ready.
  - The shadow is accepted in every state except FAULT, but commits only in RUN.
  - A shadow loaded in PRECHARGE commits at the first RUN boundary.
- **Saturation, applied on shadow load**:
  - Magnitude > MAX_MAG is replaced by MAX_MAG and marks the channel clamped.
  - Negative zero (sign=1, magnitude=0) is normalised to +0.
  - The sign bit is otherwise preserved.

## Timing
- Reset values: state=IDLE, gate_en=0, lowside_force=0, ua=ub=uc=0, commit=0, sat=0, shadow empty, so ref_ready=1.
- Commit latency: ua/ub/uc, commit and sat update on the clock edge that samples the boundary pulse. They are visible the cycle after the pulse.
- Handshake and boundary on the same cycle with the shadow empty: the new triple lands in the shadow and commits at the next boundary, not the current one.
- All outputs are registered; there are no combinational paths from inputs to outputs except ref_ready.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); the shadow is lost.
- Precharge counter: 8 bits; it saturates and never wraps.

## Configuration
- PWM_CTRL_DUAL_UPDATE_EN defined: commit boundaries are both car_min and car_max. This halves update latency.
- Undefined: only car_min is a commit boundary, and car_max is ignored entirely.
- PRECHARGE and STOP always use car_min only.

## Structure
- Package pwm_ctrl_pkg holds:
  - state enum and its codes;
  - sign bit index, magnitude width (23), reference width (24);
  - default MAX_MAG;
  - carrier peak constant 23'h22BF10, shared with the modulator.
- Sub-module pwm_ref_sat: per-channel clamp and negative-zero normalisation, producing a clamped flag. Instantiated three times at the shadow input.

## Test plan
- Arm, PRECHARGE_PERIODS=3, three car_min pulses:
  - state 0→1→2;
  - lowside_force=1 exactly until the edge of the 3rd pulse, then gate_en=1.
- RUN, load ref_ua=24'h04B606, then car_min:
  - ua=24'h04B606 one cycle later with commit=1;
  - ref_ready low from handshake until the commit.
- Load magnitude 23'h7FFFFF with sign=1:
  - ua=24'hA2BF10 and sat=1 at commit.
- Load 24'h800000:
  - committed ua=24'h000000.
- fault_n=0 during RUN:
  - next edge gives state=4, gate_en=0, ua=0;
  - fault_clr with arm=1 stays in FAULT;
  - fault_clr with arm=0 and fault_n=1 goes to IDLE.
- Handshake coincident with car_min: commit occurs at the following car_min. With PWM_CTRL_DUAL_UPDATE_EN defined, it occurs at the following car_max instead.
